// File: rtl/vc_dest_arbiter_pkg.sv
// Shared interconnect package for the VC-to-destination arbiter.
// Holds the arbiter state encoding (one-hot), default parameter values
// and the destination count used by the arbiter and its decoder.
package vc_dest_arbiter_pkg;

  localparam int BW_DEF           = 6;
  localparam int STARVE_LIMIT_DEF = 4;
  localparam int N_DEST           = 4;

  // One-hot arbiter states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'b001,
    ST_ACTIVE = 3'b010,
    ST_HOLD   = 3'b100
  } arb_state_e;

endpackage

// File: rtl/vc_dest_arbiter_dest_decoder.sv
// dest_decoder: turns a 2-bit destination index plus a valid flag into a
// one-hot destination write strobe (all zero when valid is low).
// Ports:
//   idx     in   2  destination index
//   valid   in   1  a word is being written this cycle
//   onehot  out  4  one-hot write strobe, or 0000
module dest_decoder
  import vc_dest_arbiter_pkg::*;
(
  input  logic [1:0]        idx,
  input  logic              valid,
  output logic [N_DEST-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (valid) begin
      onehot[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/vc_dest_arbiter.sv
// vc_dest_arbiter: pops words from two virtual-channel FIFOs and pushes each
// one, one cycle later, into the destination FIFO selected by the word's top
// two bits. VC0 has priority, but after STARVE_LIMIT consecutive VC0 grants
// while VC1 waits, VC1 gets one grant.
// Handshake: a pop strobe is a one-cycle read request; the FIFO presents the
// word on vc*_data the following cycle, and that same cycle the word is
// written to the destination (d_push one-hot, d_data). A popped word is
// always pushed unless reset intervenes.
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   enable                arbitration permitted
//   vc0/vc1_empty, _data  VC FIFO status and read data
//   d_almost_full [3:0]   per-destination back-pressure
//   vc0/vc1_pop           VC FIFO read strobes
//   d_push [3:0], d_data  destination write strobe and data
//   busy                  arbiter in ACTIVE or HOLD
//   state_dbg [2:0]       current one-hot FSM state
module vc_dest_arbiter
  import vc_dest_arbiter_pkg::*;
#(
  parameter int BW           = BW_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          vc0_empty,
  input  logic          vc1_empty,
  input  logic [BW-1:0] vc0_data,
  input  logic [BW-1:0] vc1_data,
  input  logic [3:0]    d_almost_full,
  output logic          vc0_pop,
  output logic          vc1_pop,
  output logic [3:0]    d_push,
  output logic [BW-1:0] d_data,
  output logic          busy,
  output logic [2:0]    state_dbg
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  arb_state_e    state_q, state_d;
  logic          pend_valid_q, pend_valid_d;
  logic          pend_vc_q, pend_vc_d;
  logic [2:0]    starve_q, starve_d;

  logic          afull_any;
  logic          pop_ok;
  logic          grant_vc0, grant_vc1;
  logic          push_valid;
  logic [BW-1:0] sel_data;

  assign afull_any = |d_almost_full;

  // VC1 wins when VC0 is empty, or when VC0 has starved it long enough.
  assign grant_vc1 = !vc1_empty && (vc0_empty || (starve_q == LIMIT));
  assign grant_vc0 = !vc0_empty && !grant_vc1;

  // State register and pending-word / starve flops.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      pend_valid_q <= 1'b0;
      pend_vc_q    <= 1'b0;
      starve_q     <= 3'd0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_vc_q    <= pend_vc_d;
      starve_q     <= starve_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (enable) state_d = ST_ACTIVE;
      ST_ACTIVE: begin
        if (!enable)        state_d = ST_IDLE;
        else if (afull_any) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!enable)         state_d = ST_IDLE;
        else if (!afull_any) state_d = ST_ACTIVE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output logic: pops, busy, and bookkeeping for the next cycle.
  // Everything is gated by reset so outputs are quiet while it is held.
  always_comb begin
    pop_ok       = reset && (state_q == ST_ACTIVE) && enable && !afull_any;
    vc0_pop      = pop_ok && grant_vc0;
    vc1_pop      = pop_ok && grant_vc1;
    busy         = reset && ((state_q == ST_ACTIVE) || (state_q == ST_HOLD));
    pend_valid_d = vc0_pop || vc1_pop;
    pend_vc_d    = vc1_pop;

    starve_d = starve_q;
    if (vc1_empty || vc1_pop) begin
      starve_d = 3'd0;
    end else if (vc0_pop && (starve_q != LIMIT)) begin
      starve_d = starve_q + 3'd1;
    end
  end

  // The popped word arrives from the FIFO this cycle; forward it.
  assign push_valid = reset && pend_valid_q;
  assign sel_data   = pend_vc_q ? vc1_data : vc0_data;
  assign d_data     = push_valid ? sel_data : '0;
  assign state_dbg  = state_q;

  dest_decoder u_dest_decoder (
    .idx    (sel_data[BW-1:BW-2]),
    .valid  (push_valid),
    .onehot (d_push)
  );

endmodule

// File: tb/tb_vc_dest_arbiter.sv
// Directed bench for vc_dest_arbiter with a behavioural model of the two VC
// FIFOs (read data appears the cycle after a pop).
module tb_vc_dest_arbiter;
  import vc_dest_arbiter_pkg::*;

  localparam int BW = 6;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          vc0_empty, vc1_empty;
  logic [BW-1:0] vc0_data = '0, vc1_data = '0;
  logic [3:0]    d_almost_full = 4'b0000;
  logic          vc0_pop, vc1_pop;
  logic [3:0]    d_push;
  logic [BW-1:0] d_data;
  logic          busy;
  logic [2:0]    state_dbg;

  int n_vec = 0;
  int n_err = 0;
  logic [BW-1:0] exp_q[$];

  vc_dest_arbiter #(.BW(BW), .STARVE_LIMIT(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .vc0_empty     (vc0_empty),
    .vc1_empty     (vc1_empty),
    .vc0_data      (vc0_data),
    .vc1_data      (vc1_data),
    .d_almost_full (d_almost_full),
    .vc0_pop       (vc0_pop),
    .vc1_pop       (vc1_pop),
    .d_push        (d_push),
    .d_data        (d_data),
    .busy          (busy),
    .state_dbg     (state_dbg)
  );

  // VC FIFO model
  logic [BW-1:0] vc0_mem [0:63];
  logic [BW-1:0] vc1_mem [0:63];
  int  vc0_wr = 0, vc1_wr = 0;
  int  vc0_rd = 0, vc1_rd = 0;
  logic flush = 1'b0;

  assign vc0_empty = (vc0_wr == vc0_rd);
  assign vc1_empty = (vc1_wr == vc1_rd);

  always @(posedge clk) begin
    if (flush) begin
      vc0_rd <= vc0_wr;
      vc1_rd <= vc1_wr;
    end else begin
      if (vc0_pop) begin
        vc0_data <= vc0_mem[vc0_rd];
        vc0_rd   <= vc0_rd + 1;
      end
      if (vc1_pop) begin
        vc1_data <= vc1_mem[vc1_rd];
        vc1_rd   <= vc1_rd + 1;
      end
    end
  end

  // Driver tasks
  task automatic load0(input logic [BW-1:0] w);
    vc0_mem[vc0_wr] = w;
    vc0_wr = vc0_wr + 1;
  endtask

  task automatic load1(input logic [BW-1:0] w);
    vc1_mem[vc1_wr] = w;
    vc1_wr = vc1_wr + 1;
  endtask

  task automatic flush_fifos();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  // Reset: outputs quiet, FSM in IDLE, even with data available and enable high.
  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; d_almost_full = 4'b0000;
    load0(6'h11);
    repeat (2) begin
      @(negedge clk); #1;
      n_vec++; if ({vc0_pop, vc1_pop} !== 2'b00) begin n_err++; $display("FAIL reset_pops: got %b expected 00", {vc0_pop, vc1_pop}); end
      n_vec++; if (d_push !== 4'b0000) begin n_err++; $display("FAIL reset_push: got %b expected 0000", d_push); end
      n_vec++; if (d_data !== 6'h00) begin n_err++; $display("FAIL reset_data: got %h expected 00", d_data); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_vec++; if (state_dbg !== 3'b001) begin n_err++; $display("FAIL reset_state: got %b expected 001", state_dbg); end
    end
    @(negedge clk);
    reset = 1'b1; enable = 1'b0;
    flush_fifos();
  endtask

  // Two VC0 words, VC1 empty: back-to-back pops, pushes one cycle later.
  task automatic test_two_words();
    load0(6'h05); load0(6'h2A);
    @(negedge clk); enable = 1'b1; #1;
    n_vec++; if (vc0_pop !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL two_idle: got pop=%b busy=%b expected 0 0", vc0_pop, busy); end
    @(negedge clk); #1;
    n_vec++; if ({vc0_pop, vc1_pop, d_push} !== 6'b10_0000) begin n_err++; $display("FAIL two_pop1: got %b expected 100000", {vc0_pop, vc1_pop, d_push}); end
    @(negedge clk); #1;
    n_vec++; if ({vc0_pop, d_push, d_data} !== {1'b1, 4'b0001, 6'h05}) begin n_err++; $display("FAIL two_push1: got pop=%b push=%b data=%h expected 1 0001 05", vc0_pop, d_push, d_data); end
    @(negedge clk); #1;
    n_vec++; if ({vc0_pop, d_push, d_data} !== {1'b0, 4'b0100, 6'h2A}) begin n_err++; $display("FAIL two_push2: got pop=%b push=%b data=%h expected 0 0100 2a", vc0_pop, d_push, d_data); end
    @(negedge clk); #1;
    n_vec++; if ({vc0_pop, vc1_pop, d_push, d_data} !== 12'h0) begin n_err++; $display("FAIL two_drained: got %b expected all zero", {vc0_pop, vc1_pop, d_push, d_data}); end
    n_vec++; if (state_dbg !== 3'b010) begin n_err++; $display("FAIL two_stay_active: got %b expected 010", state_dbg); end
    @(negedge clk); enable = 1'b0;
    @(negedge clk); #1;
    n_vec++; if (state_dbg !== 3'b001 || busy !== 1'b0) begin n_err++; $display("FAIL two_idle_end: got state=%b busy=%b expected 001 0", state_dbg, busy); end
  endtask

  // VC0 empty, VC1 loaded: VC1 granted.
  task automatic test_vc1_only();
    load1(6'h2C);
    @(negedge clk); enable = 1'b1;
    @(negedge clk); #1;
    n_vec++; if ({vc0_pop, vc1_pop} !== 2'b01) begin n_err++; $display("FAIL vc1_grant: got %b expected 01", {vc0_pop, vc1_pop}); end
    @(negedge clk); enable = 1'b0; #1;
    n_vec++; if ({d_push, d_data} !== {4'b0100, 6'h2C}) begin n_err++; $display("FAIL vc1_push: got %b %h expected 0100 2c", d_push, d_data); end
    flush_fifos();
  endtask

  // Both VCs busy: grants VC0 x4 then VC1, repeating; pushes follow in order.
  task automatic test_starve();
    logic [BW-1:0] w0 [0:11];
    logic [BW-1:0] w1 [0:3];
    int i0, i1;
    logic g1;
    logic [BW-1:0] e;
    logic [3:0] ep;
    for (int k = 0; k < 12; k++) begin w0[k] = 6'(((k % 4) << 4) | k); load0(w0[k]); end
    for (int k = 0; k < 4; k++) begin w1[k] = 6'((((k + 2) % 4) << 4) | (8 + k)); load1(w1[k]); end
    i0 = 0; i1 = 0;
    exp_q.delete();
    @(negedge clk); enable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      g1 = ((k % 5) == 4);
      n_vec++; if ({vc0_pop, vc1_pop} !== {~g1, g1}) begin n_err++; $display("FAIL starve_grant%0d: got %b expected %b", k, {vc0_pop, vc1_pop}, {~g1, g1}); end
      if (k > 0) begin
        e = exp_q.pop_front();
        ep = 4'b0001 << e[BW-1:BW-2];
        n_vec++; if ({d_push, d_data} !== {ep, e}) begin n_err++; $display("FAIL starve_push%0d: got %b %h expected %b %h", k, d_push, d_data, ep, e); end
      end
      if (g1) begin exp_q.push_back(w1[i1]); i1++; end
      else begin exp_q.push_back(w0[i0]); i0++; end
    end
    @(negedge clk); enable = 1'b0; #1;
    e = exp_q.pop_front();
    ep = 4'b0001 << e[BW-1:BW-2];
    n_vec++; if ({vc0_pop, vc1_pop, d_push, d_data} !== {2'b00, ep, e}) begin n_err++; $display("FAIL starve_last: got %b %h expected %b %h", d_push, d_data, ep, e); end
    flush_fifos();
  endtask

  // Almost-full during streaming: pops stop at once, in-flight word pushed,
  // HOLD entered, and pops resume the cycle after the flag clears.
  task automatic test_almost_full();
    load0(6'h01); load0(6'h12); load0(6'h23); load0(6'h34);
    @(negedge clk); enable = 1'b1;
    @(negedge clk); #1;
    n_vec++; if (vc0_pop !== 1'b1) begin n_err++; $display("FAIL af_pop1: got %b expected 1", vc0_pop); end
    @(negedge clk); #1;
    n_vec++; if ({vc0_pop, d_push, d_data} !== {1'b1, 4'b0001, 6'h01}) begin n_err++; $display("FAIL af_push1: got %b %b %h expected 1 0001 01", vc0_pop, d_push, d_data); end
    @(negedge clk); d_almost_full = 4'b0010; #1;
    n_vec++; if ({vc0_pop, d_push, d_data} !== {1'b0, 4'b0010, 6'h12}) begin n_err++; $display("FAIL af_inflight: got %b %b %h expected 0 0010 12", vc0_pop, d_push, d_data); end
    @(negedge clk); #1;
    n_vec++; if ({vc0_pop, d_push, state_dbg, busy} !== {1'b0, 4'b0000, 3'b100, 1'b1}) begin n_err++; $display("FAIL af_hold: got pop=%b push=%b state=%b busy=%b expected 0 0000 100 1", vc0_pop, d_push, state_dbg, busy); end
    @(negedge clk); d_almost_full = 4'b0000; #1;
    n_vec++; if ({vc0_pop, state_dbg} !== {1'b0, 3'b100}) begin n_err++; $display("FAIL af_clear: got pop=%b state=%b expected 0 100", vc0_pop, state_dbg); end
    @(negedge clk); #1;
    n_vec++; if ({vc0_pop, state_dbg} !== {1'b1, 3'b010}) begin n_err++; $display("FAIL af_resume: got pop=%b state=%b expected 1 010", vc0_pop, state_dbg); end
    @(negedge clk); enable = 1'b0; #1;
    n_vec++; if ({vc0_pop, d_push, d_data} !== {1'b0, 4'b0100, 6'h23}) begin n_err++; $display("FAIL af_push3: got %b %b %h expected 0 0100 23", vc0_pop, d_push, d_data); end
    @(negedge clk); #1;
    n_vec++; if ({state_dbg, busy, d_push} !== {3'b001, 1'b0, 4'b0000}) begin n_err++; $display("FAIL af_idle: got %b %b %b expected 001 0 0000", state_dbg, busy, d_push); end
    flush_fifos();
  endtask

  // Enable drops right after a pop: pending word still pushed, then IDLE.
  task automatic test_enable_drop();
    load0(6'h3B); load0(6'h05);
    @(negedge clk); enable = 1'b1;
    @(negedge clk); #1;
    n_vec++; if (vc0_pop !== 1'b1) begin n_err++; $display("FAIL ed_pop: got %b expected 1", vc0_pop); end
    @(negedge clk); enable = 1'b0; #1;
    n_vec++; if ({vc0_pop, d_push, d_data, busy} !== {1'b0, 4'b1000, 6'h3B, 1'b1}) begin n_err++; $display("FAIL ed_push: got %b %b %h %b expected 0 1000 3b 1", vc0_pop, d_push, d_data, busy); end
    @(negedge clk); #1;
    n_vec++; if ({state_dbg, busy, d_push, d_data} !== {3'b001, 1'b0, 4'b0000, 6'h00}) begin n_err++; $display("FAIL ed_idle: got %b %b %b %h expected 001 0 0000 00", state_dbg, busy, d_push, d_data); end
    flush_fifos();
  endtask

  // Reset the cycle after a pop: the pending word is discarded.
  task automatic test_reset_mid();
    load0(6'h17); load0(6'h26);
    @(negedge clk); enable = 1'b1;
    @(negedge clk); #1;
    n_vec++; if (vc0_pop !== 1'b1) begin n_err++; $display("FAIL rm_pop: got %b expected 1", vc0_pop); end
    @(negedge clk); reset = 1'b0; #1;
    n_vec++; if ({vc0_pop, vc1_pop, d_push, d_data, busy} !== 13'h0) begin n_err++; $display("FAIL rm_outs: got %b expected all zero", {vc0_pop, vc1_pop, d_push, d_data, busy}); end
    @(negedge clk); #1;
    n_vec++; if ({vc0_pop, vc1_pop, d_push, d_data, busy} !== 13'h0 || state_dbg !== 3'b001) begin n_err++; $display("FAIL rm_held: got %b state=%b expected all zero 001", {vc0_pop, vc1_pop, d_push, d_data, busy}, state_dbg); end
    @(negedge clk); reset = 1'b1; enable = 1'b0; #1;
    n_vec++; if ({d_push, state_dbg} !== {4'b0000, 3'b001}) begin n_err++; $display("FAIL rm_release: got %b %b expected 0000 001", d_push, state_dbg); end
    flush_fifos();
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_vc1_only();
    test_starve();
    test_almost_full();
    test_enable_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vc_dest_arbiter.md
VC_DEST_ARBITER -- requirements
Module: vc_dest_arbiter

Interface
REQ-001 Parameter: BW, 6, data word width; bits [BW-1:BW-2] are the destination index.
REQ-002 Parameter: STARVE_LIMIT, 4, maximum consecutive VC0 grants while VC1 is waiting.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  reset, synchronous, active-low.
REQ-005 enable  input  1  arbitration permitted; driven by the control FSM active_out or idle_out.
REQ-006 vc0_empty, vc1_empty  input  1 each  VC FIFO empty flags.
REQ-007 vc0_data, vc1_data  input  BW each  VC FIFO read data, valid the cycle after pop.
REQ-008 d_almost_full  input  4  per-destination FIFO almost-full flags.
REQ-009 vc0_pop, vc1_pop  output  1 each  VC FIFO read strobes.
REQ-010 d_push  output  4  destination FIFO write strobes, one-hot or zero.
REQ-011 d_data  output  BW  destination write data.
REQ-012 busy  output  1  arbiter in ACTIVE or HOLD.

Function
REQ-013 The FSM SHALL have three one-hot states: IDLE=1, ACTIVE=2, HOLD=4.
REQ-014 IDLE: no pops; go to ACTIVE when enable=1.
REQ-015 ACTIVE: on enable=0 go to IDLE; else on any d_almost_full bit =1 go to HOLD; else stay.
REQ-016 HOLD: no pops; on enable=0 go to IDLE; else on d_almost_full=0000 go to ACTIVE.
REQ-017 Pops SHALL be combinational, asserted only in ACTIVE with enable=1 and d_almost_full=0000; at most one pop per cycle.
REQ-018 Grant rule: VC0 has strict priority if non-empty, except when the starve counter equals STARVE_LIMIT and VC1 is non-empty; in that case VC1 is granted.
REQ-019 Starve counter (3 bits): increments on each VC0 grant while vc1_empty=0, saturates at STARVE_LIMIT, and clears on a VC1 grant or when vc1_empty=1.
REQ-020 A pop in cycle t SHALL register pend_valid=1 and pend_vc; in cycle t+1, d_data = the data of the selected VC and d_push[d_data[BW-1:BW-2]]=1.
REQ-021 Push latency SHALL be exactly one cycle after pop, with sustained throughput of one word per cycle.
REQ-022 A pending word SHALL always be pushed in the next cycle, even if enable drops or almost-full rises; no word is lost.
REQ-023 When pend_valid=0, d_push=0000 and d_data=0.
REQ-024 If both VCs are empty in ACTIVE, no pop occurs and the state does not change.

Reset
REQ-025 While reset=0 at a clock edge: state=IDLE, pend_valid=0, pend_vc=0, starve counter=0.
REQ-026 Reset asserted mid-transfer SHALL discard the pending word (no push in the following cycle); all outputs are 0 during reset.

Structure
REQ-027 The state encodings and the default values of BW and STARVE_LIMIT SHALL reside in the shared interconnect package.
REQ-028 A sub-module dest_decoder (2-bit index plus valid in, 4-bit one-hot out) SHALL generate d_push.

Verification
REQ-029 VC0 holds words 0x05, 0x2A; VC1 is empty; enable=1 -> pops on t, t+1; d_push=0001 with 0x05, then d_push=0100 with 0x2A.
REQ-030 Both VCs continuously non-empty -> grant pattern VC0,VC0,VC0,VC0,VC1 repeating.
REQ-031 d_almost_full=0010 raised during streaming -> pops stop the same cycle; the in-flight word is still pushed; HOLD entered; ACTIVE and pops resume the cycle after the flag clears.
REQ-032 enable dropped during a pop cycle -> the pending word is pushed next cycle, then IDLE with busy=0.
REQ-033 reset=0 asserted the cycle after a pop -> no push; all outputs are 0; state=IDLE.
